descarregador_nao_reciclavel: RTL and testbench

Drain-side controller for the non-recyclable bin; the reverse direction of the up-counter that tallies deposited items. It takes a snapshot of the counter value, then releases items one at a time to the collection mechanism. Each release uses a valid/ack handshake, with a programmable gap timer between items. It sits in the timer-and-control layer, beside the counter, and reports remaining items and completion.

---
 rtl/descarregador_nao_reciclavel_pkg.sv | 36 +++
 rtl/descarregador_nao_reciclavel_gap_timer.sv | 52 +++++
 rtl/descarregador_nao_reciclavel.sv | 159 +++++++++++++++
 tb/tb_descarregador_nao_reciclavel.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descarregador_nao_reciclavel_pkg.sv
// Shared definitions for the non-recyclable bin drain controller and the
// counter that sits beside it in the timer-and-control layer.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_CAP - tally width and bin capacity, shared with
//                                 the up-counter so both agree on the range.
//   drain_state_e               - drain FSM state encoding.
//   state_is_busy()             - decodes the busy indication from a state.
package descarregador_nao_reciclavel_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32'd4;
  localparam int unsigned DEFAULT_CAP       = 32'd10;
  localparam int unsigned DEFAULT_GAP_TICKS = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_OFFER = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // The mechanism is considered busy while it is spacing or offering items;
  // the completion state is not busy.
  function automatic logic state_is_busy(input drain_state_e st);
    logic busy_v;
    case (st)
      ST_GAP:   busy_v = 1'b1;
      ST_OFFER: busy_v = 1'b1;
      ST_IDLE:  busy_v = 1'b0;
      ST_DONE:  busy_v = 1'b0;
      default:  busy_v = 1'b0;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/descarregador_nao_reciclavel_gap_timer.sv
// Loadable down-counter used to space successive items handed to the
// collection mechanism. Any timer-and-control block can reuse it.
//
// Ports:
//   clock    - system clock, rising edge
//   clear_n  - asynchronous active-low reset, clears the count to zero
//   reload   - load 'value' on the next rising edge (has priority)
//   value    - count to load
//   zero     - high while the count is zero
//
// The count decrements every cycle and saturates at zero, so a caller only
// needs to reload it and watch 'zero'.
module descarregador_nao_reciclavel_gap_timer #(
  parameter int unsigned TW = 32'd2
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          reload,
  input  logic [TW-1:0] value,
  output logic          zero
);

  localparam logic [TW-1:0] ZERO_W = {TW{1'b0}};
  localparam logic [TW-1:0] ONE_W  = TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: reload wins, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = value;
    end else if (count_q != ZERO_W) begin
      count_d = count_q - ONE_W;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= ZERO_W;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == ZERO_W);

endmodule

// File: rtl/descarregador_nao_reciclavel.sv
// Drain-side controller for the non-recyclable bin. It snapshots the tally
// from the up-counter (clamped to bin capacity), then releases the items one
// at a time over a valid/ack handshake, waiting GAP_TICKS cycles before each
// offer.
//
// Ports:
//   clock      - system clock, rising edge
//   clear_n    - asynchronous active-low reset
//   load       - capture count_in (IDLE only, has priority over start)
//   count_in   - current tally from the non-recyclable counter
//   start      - begin draining (IDLE only)
//   ack        - consumer accepts the offered item (OFFER only)
//   item_valid - an item is offered, held until ack
//   remaining  - items still to drain
//   busy       - high while spacing or offering items
//   done       - one-cycle completion pulse
//   overflow   - sticky: the last load exceeded CAP
//
// All outputs come straight from flops. item_valid and busy are registered
// from the next state so they line up with the state register; done is
// registered from the DONE state, so it appears the cycle after DONE is
// entered (two cycles after a start on an empty bin). There is no
// combinational path from ack to any output.
module descarregador_nao_reciclavel
  import descarregador_nao_reciclavel_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CAP       = DEFAULT_CAP,
  parameter int unsigned GAP_TICKS = DEFAULT_GAP_TICKS   // must be >= 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  input  logic             start,
  input  logic             ack,
  output logic             item_valid,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  // Timer only ever holds GAP_TICKS-1, so clog2(GAP_TICKS) bits suffice.
  localparam int unsigned TW = (GAP_TICKS > 32'd1) ? $clog2(GAP_TICKS) : 32'd1;

  localparam logic [WIDTH-1:0] CAP_W  = WIDTH'(CAP);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [TW-1:0]    GAP_RELOAD = TW'(GAP_TICKS - 32'd1);

  drain_state_e     state_q;
  drain_state_e     state_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] remaining_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             item_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             timer_reload_s;
  logic             timer_zero_s;

  descarregador_nao_reciclavel_gap_timer #(
    .TW (TW)
  ) u_gap_timer (
    .clock   (clock),
    .clear_n (clear_n),
    .reload  (timer_reload_s),
    .value   (GAP_RELOAD),
    .zero    (timer_zero_s)
  );

  // Next-state, snapshot and overflow logic for the drain sequence.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    overflow_d     = overflow_q;
    timer_reload_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          // Load beats a simultaneous start; clamp to what the bin can hold.
          if (count_in > CAP_W) begin
            remaining_d = CAP_W;
            overflow_d  = 1'b1;
          end else begin
            remaining_d = count_in;
            overflow_d  = 1'b0;
          end
        end else if (start) begin
          if (remaining_q != ZERO_W) begin
            state_d        = ST_GAP;
            timer_reload_s = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        // The timer was loaded with GAP_TICKS-1 on entry, so GAP lasts
        // exactly GAP_TICKS cycles.
        if (timer_zero_s) begin
          state_d = ST_OFFER;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_OFFER: begin
        // remaining is at least 1 here, so the decrement cannot wrap.
        if (ack) begin
          remaining_d = remaining_q - ONE_W;
          if (remaining_q == ONE_W) begin
            state_d = ST_DONE;
          end else begin
            state_d        = ST_GAP;
            timer_reload_s = 1'b1;
          end
        end else begin
          state_d = ST_OFFER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and registered output flops.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= ZERO_W;
      overflow_q   <= 1'b0;
      item_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      overflow_q   <= overflow_d;
      item_valid_q <= (state_d == ST_OFFER);
      busy_q       <= state_is_busy(state_d);
      done_q       <= (state_q == ST_DONE);
    end
  end

  assign item_valid = item_valid_q;
  assign remaining  = remaining_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_descarregador_nao_reciclavel.sv
// Directed bench for the non-recyclable drain controller (WIDTH=4, CAP=10,
// GAP_TICKS=3). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point. Latencies are counted in clock edges from the
// cycle in which the stimulus is driven.
module tb_descarregador_nao_reciclavel;

  logic       clock;
  logic       clear_n;
  logic       load;
  logic [3:0] count_in;
  logic       start;
  logic       ack;
  logic       item_valid;
  logic [3:0] remaining;
  logic       busy;
  logic       done;
  logic       overflow;

  int vec_cnt;
  int miss_cnt;

  descarregador_nao_reciclavel #(
    .WIDTH     (32'd4),
    .CAP       (32'd10),
    .GAP_TICKS (32'd3)
  ) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .load       (load),
    .count_in   (count_in),
    .start      (start),
    .ack        (ack),
    .item_valid (item_valid),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Edges until item_valid, counting the edge that sampled the stimulus.
  task automatic wait_valid(output int n);
    n = 1;
    while (item_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; count_in = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; load = 1'b0; count_in = 4'd0; start = 1'b0; ack = 1'b0;
    #12;
    vec_cnt++;
    if ({item_valid, busy, done, overflow, remaining} !== 8'h00) begin
      miss_cnt++;
      $display("FAIL reset_outputs got iv=%b busy=%b done=%b ovf=%b rem=%0d want all 0",
               item_valid, busy, done, overflow, remaining);
    end
    @(negedge clock);
    clear_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_drain();
    int n;
    int hs;
    do_load(4'd3);
    vec_cnt++;
    if (remaining !== 4'd3 || overflow !== 1'b0) begin
      miss_cnt++;
      $display("FAIL drain_load got rem=%0d ovf=%b want 3 0", remaining, overflow);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    hs = 0;
    for (int k = 3; k >= 1; k--) begin
      wait_valid(n);
      vec_cnt++;
      if (n !== 4) begin
        miss_cnt++;
        $display("FAIL drain_latency item %0d got %0d want 4", k, n);
      end
      if (item_valid === 1'b1) hs++;
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      vec_cnt++;
      if (remaining !== 4'(k - 1) || item_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL drain_step got rem=%0d iv=%b want %0d 0", remaining, item_valid, k - 1);
      end
    end
    vec_cnt++;
    if (hs !== 3) begin
      miss_cnt++;
      $display("FAIL drain_handshakes got %0d want 3", hs);
    end
    vec_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL drain_enter_done got busy=%b done=%b want 0 0", busy, done);
    end
    cyc();
    vec_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL drain_done_pulse got done=%b busy=%b want 1 0", done, busy);
    end
    cyc();
    vec_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || item_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL drain_after got done=%b busy=%b iv=%b want 0 0 0", done, busy, item_valid);
    end
  endtask

  task automatic test_clamp();
    do_load(4'd13);
    vec_cnt++;
    if (remaining !== 4'd10 || overflow !== 1'b1) begin
      miss_cnt++;
      $display("FAIL clamp_13 got rem=%0d ovf=%b want 10 1", remaining, overflow);
    end
    do_load(4'd10);
    vec_cnt++;
    if (remaining !== 4'd10 || overflow !== 1'b0) begin
      miss_cnt++;
      $display("FAIL clamp_cap got rem=%0d ovf=%b want 10 0", remaining, overflow);
    end
    do_load(4'd11);
    do_load(4'd4);
    vec_cnt++;
    if (remaining !== 4'd4 || overflow !== 1'b0) begin
      miss_cnt++;
      $display("FAIL clamp_clear got rem=%0d ovf=%b want 4 0", remaining, overflow);
    end
    // load beats a simultaneous start
    load = 1'b1; start = 1'b1; count_in = 4'd6;
    cyc();
    load = 1'b0; start = 1'b0;
    cyc();
    vec_cnt++;
    if (remaining !== 4'd6 || busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL load_wins got rem=%0d busy=%b want 6 0", remaining, busy);
    end
  endtask

  task automatic test_empty_start();
    do_load(4'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    vec_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || item_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL empty_edge1 got done=%b busy=%b iv=%b want 0 0 0", done, busy, item_valid);
    end
    cyc();
    vec_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || item_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL empty_edge2 got done=%b busy=%b iv=%b want 1 0 0", done, busy, item_valid);
    end
    cyc();
    vec_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL empty_edge3 got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stall_ignored();
    int n;
    do_load(4'd2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid(n);
    // stall in OFFER while pulsing load with a new tally
    for (int i = 0; i < 5; i++) begin
      load = (i % 2 == 0); count_in = 4'd7;
      cyc();
      vec_cnt++;
      if (item_valid !== 1'b1 || remaining !== 4'd2 || busy !== 1'b1 || overflow !== 1'b0) begin
        miss_cnt++;
        $display("FAIL stall_cycle %0d got iv=%b rem=%0d busy=%b want 1 2 1", i, item_valid, remaining, busy);
      end
    end
    load = 1'b0;
    ack = 1'b1;
    cyc();
    // second ack pulse lands in GAP and must be ignored; start too
    start = 1'b1;
    cyc();
    ack = 1'b0; start = 1'b0;
    vec_cnt++;
    if (remaining !== 4'd1 || item_valid !== 1'b0 || busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL gap_ack_ignored got rem=%0d iv=%b busy=%b want 1 0 1", remaining, item_valid, busy);
    end
    wait_valid(n);
    vec_cnt++;
    // ack edge, then 3 GAP edges ending in OFFER; already 2 edges in
    if (n !== 3 || remaining !== 4'd1) begin
      miss_cnt++;
      $display("FAIL gap_latency got n=%0d rem=%0d want 3 1", n, remaining);
    end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc();
    cyc();
    vec_cnt++;
    if (remaining !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL stall_finish got rem=%0d busy=%b done=%b want 0 0 0", remaining, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_load(4'd3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid(n);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    wait_valid(n);
    vec_cnt++;
    if (item_valid !== 1'b1 || remaining !== 4'd2) begin
      miss_cnt++;
      $display("FAIL mid_setup got iv=%b rem=%0d want 1 2", item_valid, remaining);
    end
    #2;
    clear_n = 1'b0;
    #1;
    vec_cnt++;
    if (item_valid !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) begin
      miss_cnt++;
      $display("FAIL mid_async_reset got iv=%b busy=%b rem=%0d want 0 0 0", item_valid, busy, remaining);
    end
    cyc();
    clear_n = 1'b1;
    cyc();
    cyc();
    vec_cnt++;
    if (item_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL mid_release got iv=%b busy=%b done=%b want 0 0 0", item_valid, busy, done);
    end
    // only IDLE honours load
    do_load(4'd5);
    vec_cnt++;
    if (remaining !== 4'd5) begin
      miss_cnt++;
      $display("FAIL mid_idle_load got rem=%0d want 5", remaining);
    end
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    test_reset();
    test_basic_drain();
    test_clamp();
    test_empty_start();
    test_stall_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
